// File: rtl/hack_exec_if.sv
// Handshake and ALU bundle between the Hack execution controller (master)
// and its instruction memory, data memory and ALU (slave).
interface hack_exec_if #(parameter int PC_W = 15);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [15:0]     imem_data;
  logic            dmem_rd;
  logic            dmem_wr;
  logic [PC_W-1:0] dmem_addr;
  logic [15:0]     dmem_wdata;
  logic [15:0]     dmem_rdata;
  logic            dmem_ack;
  logic [15:0]     alu_x;
  logic [15:0]     alu_y;
  logic            alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0]     alu_out;
  logic            alu_zr;
  logic            alu_ng;
  logic [PC_W-1:0] pc;
  logic [15:0]     a_reg;
  logic [15:0]     d_reg;

  modport master (
    output imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
           alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
           pc, a_reg, d_reg,
    input  imem_valid, imem_data, dmem_rdata, dmem_ack, alu_out, alu_zr, alu_ng
  );

  modport slave (
    input  imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
           alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
           pc, a_reg, d_reg,
    output imem_valid, imem_data, dmem_rdata, dmem_ack, alu_out, alu_zr, alu_ng
  );
endinterface

// File: rtl/hack_exec_ctrl.sv
// Multi-cycle fetch/decode/execute controller for a Hack CPU: owns PC, A, D
// and IR, drives the external ALU and sequences imem/dmem handshakes.
module hack_exec_ctrl #(
  parameter int              PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  hack_exec_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, MEMRD, EXEC, MEMWR} state_t;

  state_t          state;
  logic [15:0]     ir, a, d, m, wdata;
  logic [PC_W-1:0] pc, pc_hold, addr;
  logic            imem_req, dmem_rd, dmem_wr;
  logic [5:0]      ctl;
  logic            jmp;
  logic [PC_W-1:0] pc_inc, pc_next;

  assign pc_inc  = pc + 1'b1;
  assign jmp     = (ir[2] & bus.alu_ng) | (ir[1] & bus.alu_zr) |
                   (ir[0] & ~bus.alu_zr & ~bus.alu_ng);
  // Jump target is A as it stood before this EXEC, even if d1 rewrites A.
  assign pc_next = jmp ? a[PC_W-1:0] : pc_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      pc_hold  <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      d        <= '0;
      m        <= '0;
      wdata    <= '0;
      addr     <= '0;
      ctl      <= '0;
      imem_req <= 1'b0;
      dmem_rd  <= 1'b0;
      dmem_wr  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // First FETCH after reset spends one cycle raising the request.
          imem_req <= 1'b1;
          if (imem_req && bus.imem_valid) begin
            ir       <= bus.imem_data;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          if (!ir[15]) begin
            a        <= {1'b0, ir[14:0]};
            pc       <= pc_inc;
            imem_req <= 1'b1;
            state    <= FETCH;
          end else if (ir[12]) begin
            dmem_rd <= 1'b1;
            addr    <= a[PC_W-1:0];
            state   <= MEMRD;
          end else begin
            ctl   <= ir[11:6];
            state <= EXEC;
          end
        end
        MEMRD: begin
          if (bus.dmem_ack) begin
            m       <= bus.dmem_rdata;
            dmem_rd <= 1'b0;
            ctl     <= ir[11:6];
            state   <= EXEC;
          end
        end
        EXEC: begin
          ctl   <= '0;
          wdata <= bus.alu_out;
          addr  <= a[PC_W-1:0];
          if (ir[5]) a <= bus.alu_out;
          if (ir[4]) d <= bus.alu_out;
          if (ir[3]) begin
            pc_hold <= pc_next;
            dmem_wr <= 1'b1;
            state   <= MEMWR;
          end else begin
            pc       <= pc_next;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        MEMWR: begin
          if (bus.dmem_ack) begin
            dmem_wr  <= 1'b0;
            pc       <= pc_hold;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.imem_req   = imem_req;
  assign bus.imem_addr  = pc;
  assign bus.dmem_rd    = dmem_rd;
  assign bus.dmem_wr    = dmem_wr;
  assign bus.dmem_addr  = addr;
  assign bus.dmem_wdata = wdata;
  assign bus.alu_x      = d;
  assign bus.alu_y      = ir[12] ? m : a;
  assign {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} = ctl;
  assign bus.pc         = pc;
  assign bus.a_reg      = a;
  assign bus.d_reg      = d;
endmodule

// File: tb/tb_hack_exec_ctrl.sv
// Scoreboard bench: an instruction-level Hack model predicts post-instruction
// state, memory traffic and latency; a monitor checks what the DUT presents.
module tb_hack_exec_ctrl;
  localparam int PC_W = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hack_exec_if #(.PC_W(PC_W)) bus();
  hack_exec_ctrl #(.PC_W(PC_W), .RESET_PC('0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [14:0] pc;
    logic [15:0] a;
    logic [15:0] d;
    int          due;
  } st_t;
  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  st_t         stq[$];
  wr_t         wrq[$];
  logic [14:0] rdq[$];
  int          dwq[$];
  logic [15:0] prog[$];

  logic [15:0] ram  [0:32767];
  logic [15:0] mref [0:32767];
  logic [14:0] m_pc;
  logic [15:0] m_a, m_d;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   iwait = 0;
  int   dwait = 0;
  logic dbusy = 1'b0;
  logic hold_ack = 1'b0;
  logic pr = 1'b0, prd = 1'b0, pwr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] hack_alu(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p, q, o;
    p = c[5] ? 16'h0 : x;
    if (c[4]) p = ~p;
    q = c[3] ? 16'h0 : y;
    if (c[2]) q = ~q;
    o = c[1] ? p + q : p & q;
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign bus.alu_out = hack_alu({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no},
                                bus.alu_x, bus.alu_y);
  assign bus.alu_zr  = (bus.alu_out == 16'h0);
  assign bus.alu_ng  = bus.alu_out[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Architectural effect of one instruction, plus expected cycles until the next fetch request.
  task automatic model_exec(input logic [15:0] ins);
    logic [15:0] y, r;
    logic [14:0] wa;
    logic        jump;
    int          lat, w;
    if (!ins[15]) begin
      m_a  = {1'b0, ins[14:0]};
      m_pc = m_pc + 15'd1;
      lat  = 1;
    end else begin
      lat = 2;
      wa  = m_a[14:0];
      if (ins[12]) begin
        y = mref[wa];
        rdq.push_back(wa);
        w = $urandom_range(0, 2);
        dwq.push_back(w);
        lat += 1 + w;
      end else begin
        y = m_a;
      end
      r = hack_alu(ins[11:6], m_d, y);
      if (ins[3]) begin
        mref[wa] = r;
        wrq.push_back('{addr: wa, data: r});
        w = $urandom_range(0, 2);
        dwq.push_back(w);
        lat += 1 + w;
      end
      jump = (ins[2] && $signed(r) < 0) || (ins[1] && r == 16'h0) || (ins[0] && $signed(r) > 0);
      if (ins[5]) m_a = r;
      if (ins[4]) m_d = r;
      m_pc = jump ? wa : m_pc + 15'd1;
    end
    stq.push_back('{pc: m_pc, a: m_a, d: m_d, due: cyc + 1 + lat});
  endtask

  function automatic logic [15:0] rand_instr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 16'h7FFF;
    if (k < 4)  return {1'b0, 15'($urandom_range(0, 127))};
    return {1'b1, 15'($urandom)};
  endfunction

  // Instruction memory responder
  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_data  = 16'h0;
    forever begin
      @(negedge clk);
      bus.imem_valid = 1'b0;
      if (rst_n && bus.imem_req && prog.size() > 0) begin
        if (iwait > 0) iwait--;
        else begin
          bus.imem_data  = prog.pop_front();
          bus.imem_valid = 1'b1;
          model_exec(bus.imem_data);
          iwait = $urandom_range(0, 2);
        end
      end
    end
  end

  // Data memory responder; wait states come from the model so latency is predictable
  initial begin
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (!hold_ack) begin
        bus.dmem_ack = 1'b0;
        if (rst_n && (bus.dmem_rd || bus.dmem_wr)) begin
          if (!dbusy) begin
            dbusy = 1'b1;
            dwait = (dwq.size() > 0) ? dwq.pop_front() : 0;
          end
          if (dwait == 0) begin
            bus.dmem_ack = 1'b1;
            dbusy = 1'b0;
            if (bus.dmem_wr) ram[bus.dmem_addr] = bus.dmem_wdata;
            else bus.dmem_rdata = ram[bus.dmem_addr];
          end else begin
            dwait--;
          end
        end
      end
    end
  end

  // Monitor
  initial begin
    st_t         e;
    wr_t         ew;
    logic [14:0] er;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (bus.imem_req && !pr) begin
          if (stq.size() == 0) fail_now("state_queue_underflow");
          else begin
            e = stq.pop_front();
            check("pc", 32'(bus.pc), 32'(e.pc));
            check("imem_addr", 32'(bus.imem_addr), 32'(e.pc));
            check("a_reg", 32'(bus.a_reg), 32'(e.a));
            check("d_reg", 32'(bus.d_reg), 32'(e.d));
            if (e.due >= 0) check("latency", 32'(cyc), 32'(e.due));
          end
        end
        if (bus.dmem_rd && !prd) begin
          if (rdq.size() == 0) fail_now("unexpected_dmem_rd");
          else begin
            er = rdq.pop_front();
            check("rd_addr", 32'(bus.dmem_addr), 32'(er));
          end
        end
        if (bus.dmem_wr && !pwr) begin
          if (wrq.size() == 0) fail_now("unexpected_dmem_wr");
          else begin
            ew = wrq.pop_front();
            check("wr_addr", 32'(bus.dmem_addr), 32'(ew.addr));
            check("wr_data", 32'(bus.dmem_wdata), 32'(ew.data));
          end
        end
        check("req_exclusive", 32'(int'(bus.dmem_rd) + int'(bus.dmem_wr) + int'(bus.imem_req) > 1), 32'd0);
        if (bus.imem_req || bus.dmem_rd || bus.dmem_wr)
          check("alu_ctl_idle", 32'({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}), 32'd0);
      end
      pr  = bus.imem_req;
      prd = bus.dmem_rd;
      pwr = bus.dmem_wr;
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((prog.size() > 0 || stq.size() > 0) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) fail_now(name);
  endtask

  task automatic reset_model();
    stq.delete(); wrq.delete(); rdq.delete(); dwq.delete(); prog.delete();
    m_pc = '0; m_a = '0; m_d = '0;
    dbusy = 1'b0;
    stq.push_back('{pc: 15'd0, a: 16'd0, d: 16'd0, due: -1});
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32768; i++) begin
      ram[i]  = 16'($urandom);
      mref[i] = ram[i];
    end
    ram[100]  = 16'd7;
    mref[100] = 16'd7;
    reset_model();

    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_dmem_rd", 32'(bus.dmem_rd), 32'd0);
    check("rst_dmem_wr", 32'(bus.dmem_wr), 32'd0);
    check("rst_alu_ctl", 32'({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}), 32'd0);
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_a", 32'(bus.a_reg), 32'd0);
    check("rst_d", 32'(bus.d_reg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // A=5; D=A; A=100; M=M-1; D=0; A=40; D;JEQ; D=A... ; 0;JMP to 0x7FFF; A=9 wraps PC; AM=-1
    foreach (prog[i]) ;
    prog.push_back(16'h0005); prog.push_back(16'hEC10);
    prog.push_back(16'h0064); prog.push_back(16'hFC88);
    prog.push_back(16'hEA90); prog.push_back(16'h0028); prog.push_back(16'hE302);
    prog.push_back(16'h0003); prog.push_back(16'hEC10);
    prog.push_back(16'h0028); prog.push_back(16'hE302);
    prog.push_back(16'h7FFF); prog.push_back(16'hEA87);
    prog.push_back(16'h0009); prog.push_back(16'hEEA8);
    for (int i = 0; i < 400; i++) prog.push_back(rand_instr());
    drain("drain_timeout_main");

    // Reset while a write waits for its ack; the ack arriving in the reset cycle must be ignored
    hold_ack = 1'b1;
    prog.push_back(16'h0032);
    prog.push_back(16'hE308);
    n = 0;
    while (!bus.dmem_wr && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) fail_now("memwr_wait_timeout");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    bus.dmem_ack = 1'b1;
    @(posedge clk);
    #1;
    check("rstwr_dmem_wr", 32'(bus.dmem_wr), 32'd0);
    check("rstwr_imem_req", 32'(bus.imem_req), 32'd0);
    check("rstwr_pc", 32'(bus.pc), 32'd0);
    check("rstwr_a", 32'(bus.a_reg), 32'd0);
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    reset_model();
    mref[50] = ram[50];
    hold_ack = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) prog.push_back(rand_instr());
    drain("drain_timeout_post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
